// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: opcodes, ALUOp codes and FSM states shared by the multicycle sequencer
package multicycle_ctrl_pkg;
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] U_TYPE = 7'b0110111;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASS  = 2'b11;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  function automatic logic is_known(input logic [6:0] op);
    return op inside {R_TYPE, I_TYPE, U_TYPE, LW, SW, BR, JAL, JALR};
  endfunction
endpackage

// File: rtl/multicycle_ctrl_mem_watchdog.sv
// multicycle_ctrl_mem_watchdog: counts unanswered memory request cycles and flags a timeout
module multicycle_ctrl_mem_watchdog #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic active,
  input  logic ready,
  output logic expired
);
  logic [CNT_W-1:0] r_cnt;
  // Wait counter: restarts per request, advances on every unanswered request cycle
  always_ff @(posedge clk) begin
    if (reset || clear) r_cnt <= '0;
    else if (active && !ready) r_cnt <= r_cnt + CNT_W'(1);
  end
  // Fires in the cycle the counter would reach TIMEOUT; a ready in that cycle still wins
  assign expired = active && !ready && (r_cnt == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer; MULTICYCLE_CTRL_ILLEGAL_TRAP_EN halts on unknown opcodes
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_inc,
  output logic       pc_jump,
  output logic       Branch,
  output logic       ALUSrc,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       link_sel,
  output logic       instr_done,
  output logic       bus_err,
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  output logic       halted,
  output logic       illegal_instr
`else
  output logic       halted
`endif
);
  state_t     r_state, w_next;
  logic [6:0] r_opcode;
  logic       r_bus_err;
  logic       w_active, w_clear, w_expired;

  assign w_active = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_clear  = !w_active || mem_ready;
  assign bus_err  = r_bus_err && !reset;

  multicycle_ctrl_mem_watchdog #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_clear),
    .active (w_active),
    .ready  (mem_ready),
    .expired(w_expired)
  );

  // State, latched opcode and sticky bus error
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_opcode  <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= Opcode;
      if (w_expired) r_bus_err <= 1'b1;
    end
  end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;
  // Sticky flag for an unrecognised opcode seen in DECODE
  always_ff @(posedge clk) begin
    if (reset) r_illegal <= 1'b0;
    else if (r_state == S_DECODE && !is_known(Opcode)) r_illegal <= 1'b1;
  end
  assign illegal_instr = r_illegal && !reset;
`endif

  // Next state and control strobes; everything is held low while reset is asserted
  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_inc     = 1'b0;
    pc_jump    = 1'b0;
    Branch     = 1'b0;
    ALUSrc     = 1'b0;
    ALUOp      = ALU_ADD;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    link_sel   = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_req  = 1'b1;
          MemRead  = 1'b1;
          ir_write = mem_ready;
          pc_inc   = mem_ready;
          w_next   = mem_ready ? S_DECODE : w_expired ? S_HALT : S_FETCH;
        end
        S_DECODE: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          w_next = is_known(Opcode) ? S_EXEC : S_HALT;
`else
          instr_done = !is_known(Opcode);
          w_next     = is_known(Opcode) ? S_EXEC : S_FETCH;
`endif
        end
        S_EXEC: begin
          case (r_opcode)
            R_TYPE: begin ALUOp = ALU_FUNCT; w_next = S_WB; end
            I_TYPE: begin ALUOp = ALU_FUNCT; ALUSrc = 1'b1; w_next = S_WB; end
            U_TYPE: begin ALUOp = ALU_PASS; ALUSrc = 1'b1; w_next = S_WB; end
            LW, SW: begin ALUSrc = 1'b1; w_next = S_MEM; end
            BR: begin ALUOp = ALU_BR; Branch = 1'b1; instr_done = 1'b1; w_next = S_FETCH; end
            JAL, JALR: begin ALUSrc = 1'b1; pc_jump = 1'b1; w_next = S_WB; end
            default: w_next = S_FETCH;
          endcase
        end
        S_MEM: begin
          mem_req    = 1'b1;
          iord       = 1'b1;
          MemRead    = r_opcode == LW;
          MemWrite   = r_opcode == SW;
          instr_done = mem_ready && r_opcode == SW;
          w_next     = mem_ready ? (r_opcode == LW ? S_WB : S_FETCH) : w_expired ? S_HALT : S_MEM;
        end
        S_WB: begin
          RegWrite   = 1'b1;
          MemtoReg   = r_opcode == LW;
          link_sel   = r_opcode == JAL || r_opcode == JALR;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_HALT: halted = 1'b1;
        default: w_next = S_FETCH;
      endcase
    end
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle sequencer for the RV32I-subset core. One shared instruction/data memory port, one ALU.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB. Drives the same control set as the single-cycle decoder (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch) plus sequencing strobes.
- Handshakes with variable-latency memory via req/ready, with a wait-timeout watchdog.

Parameters:
- TIMEOUT, 16: max cycles mem_req may stay high without mem_ready before bus error; 1..255.
- CNT_W, 8: width of the wait counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- Opcode  in  7  IR[6:0]; valid from the DECODE cycle onward
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request; held until mem_ready
- MemRead  out  1  request is a read (fetch or LW)
- MemWrite  out  1  request is a write (SW)
- iord  out  1  0: address=PC; 1: address=ALUOut
- ir_write  out  1  load IR from read data
- pc_inc  out  1  PC<=PC+4 (old PC saved by datapath)
- pc_jump  out  1  PC<=ALU target (JAL/JALR)
- Branch  out  1  conditional PC update (datapath gates with zero flag)
- ALUSrc  out  1  0: rs2; 1: immediate
- ALUOp  out  2  00 add, 01 branch/compare, 10 funct-decoded, 11 pass-imm/link
- RegWrite  out  1  register-file write strobe
- MemtoReg  out  1  write-back from memory data
- link_sel  out  1  write-back value is PC+4
- instr_done  out  1  one-cycle pulse per retired instruction
- bus_err  out  1  sticky; memory timeout
- halted  out  1  FSM in HALT

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset:
  - state <= FETCH; opcode register, wait counter and bus_err cleared.
  - All outputs 0 while reset is high, including mid-transaction; any outstanding request is dropped.
- Outputs:
  - Moore, decoded from state and the latched opcode.
  - Exceptions: ir_write, pc_inc, instr_done are Mealy pulses qualified by mem_ready or state exit, as stated below.
- FETCH:
  - mem_req=1, MemRead=1, iord=0.
  - On mem_ready: ir_write=1 and pc_inc=1 in the same cycle, then go to DECODE. Otherwise stay.
- DECODE:
  - Latch Opcode.
  - R/I/LUI/LW/SW/BR/JAL/JALR go to EXEC.
  - Any other opcode: instr_done=1, go to FETCH (treated as NOP).
- EXEC, by latched opcode:
  - R 0110011: ALUOp=10, ALUSrc=0, go to WB.
  - I 0010011: ALUOp=10, ALUSrc=1, go to WB.
  - LUI 0110111: ALUOp=11, ALUSrc=1, go to WB.
  - LW/SW: ALUOp=00, ALUSrc=1, go to MEM.
  - BR 1100011: ALUOp=01, ALUSrc=0, Branch=1, instr_done=1, go to FETCH.
  - JAL/JALR: ALUOp=00, ALUSrc=1, pc_jump=1, go to WB.
- MEM:
  - mem_req=1, iord=1; MemRead=1 for LW, MemWrite=1 for SW.
  - On mem_ready: LW goes to WB; SW sets instr_done=1 and goes to FETCH.
- WB:
  - RegWrite=1, one cycle.
  - MemtoReg=1 for LW; link_sel=1 for JAL/JALR.
  - instr_done=1, go to FETCH.
- Latency with zero-wait memory (mem_ready in the first request cycle):
  - BR = 3 cycles.
  - R/I/LUI/SW/JAL/JALR = 4 cycles.
  - LW = 5 cycles.
  - Each wait cycle adds 1.
- Watchdog:
  - Wait counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 and mem_ready=0.
  - When it reaches TIMEOUT: drop mem_req, set bus_err, go to HALT.
  - mem_ready in the same cycle the counter reaches TIMEOUT counts as success.
- mem_ready outside FETCH/MEM is ignored.
- HALT: all strobes 0, halted=1. Exit only via reset.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE goes to HALT instead of FETCH.
  - Sets output illegal_instr (1 bit, sticky, cleared by reset); no instr_done pulse.
  - The illegal_instr port exists only when the macro is defined.
- Undefined: unknown opcodes retire as NOP and the port is absent.

Decomposition:
- Shared package, e.g. rv_ctrl_pkg:
  - Opcode localparams (R_TYPE, I_TYPE, U_TYPE, LW, SW, BR, JAL, JALR).
  - ALUOp encodings.
  - State enum typedef.
- Sub-module mem_watchdog: wait counter plus timeout compare, with inputs clear/active/ready and output expired.

Test Plan:
- ADD (0110011), mem_ready always 1 → ir_write/pc_inc in cycle 1, RegWrite in cycle 4 with ALUOp=10, ALUSrc=0; instr_done in cycle 4.
- LW (0000011), fetch ready after 2 waits, data ready after 1 wait → MEM has MemRead=1, iord=1; WB has MemtoReg=1, RegWrite=1; total 8 cycles.
- SW then BEQ, zero-wait → SW: MemWrite=1 for 1 cycle, no RegWrite, 4 cycles; BEQ: Branch=1 in cycle 3, 3 cycles total.
- JAL (1101111) → pc_jump=1 in EXEC, then RegWrite=1 with link_sel=1 in WB.
- mem_ready held 0 in FETCH, TIMEOUT=4 → bus_err=1 and halted=1 after 4 wait cycles; reset returns to FETCH with all outputs 0.
- Opcode 1111111 → NOP path: FETCH reached after 2 cycles, instr_done=1. With the macro defined: halted=1 and illegal_instr=1 instead.
